// File: rtl/xge_tx_sched.sv
// xge_tx_sched: round-robin frame scheduler in front of the 10GE MAC packet-TX port.
// Grants whole frames, honours MAC back-pressure, inserts an idle gap after each frame,
// truncates oversize frames and keeps saturating frame/error counters.
module xge_tx_sched #(
    parameter int NUM_REQ    = 2,
    parameter int IFG_CYCLES = 3,
    parameter int MAX_BEATS  = 190,
    parameter int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk_156m25,
    input  logic                  reset_156m25_n,
    input  logic [NUM_REQ-1:0]    req_val,
    input  logic [NUM_REQ-1:0]    req_sop,
    input  logic [NUM_REQ-1:0]    req_eop,
    input  logic [NUM_REQ*64-1:0] req_data,
    input  logic [NUM_REQ*3-1:0]  req_mod,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  pkt_tx_full,
    output logic                  pkt_tx_val,
    output logic                  pkt_tx_sop,
    output logic                  pkt_tx_eop,
    output logic [63:0]           pkt_tx_data,
    output logic [2:0]            pkt_tx_mod,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic [31:0]           frame_cnt,
    output logic [15:0]           err_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XFER  = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    // With no idle gap configured a finished frame returns straight to arbitration.
    localparam logic [1:0] S_POST  = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
    localparam int unsigned NREQ   = NUM_REQ;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [7:0]    beat_q, beat_d;
    logic [7:0]    gap_q, gap_d;
    logic          tx_val_q, tx_val_d;
    logic          tx_sop_q, tx_sop_d;
    logic          tx_eop_q, tx_eop_d;
    logic [63:0]   tx_data_q, tx_data_d;
    logic [2:0]    tx_mod_q, tx_mod_d;
    logic [31:0]   frame_q, frame_d;
    logic [15:0]   err_q, err_d;
    logic          frame_inc, err_inc;

    logic          sel_val, sel_sop, sel_eop;
    logic [63:0]   sel_data;
    logic [2:0]    sel_mod;
    logic [NUM_REQ-1:0] cand;

    // Beat presented by the currently granted requester.
    always_comb begin
        sel_val  = req_val[grant_q];
        sel_sop  = req_sop[grant_q];
        sel_eop  = req_eop[grant_q];
        sel_data = req_data[64*32'(grant_q) +: 64];
        sel_mod  = req_mod[3*32'(grant_q) +: 3];
        cand     = req_val & req_sop;
    end

    // Ready goes only to the granted requester; drained beats ignore back-pressure.
    always_comb begin
        req_ready = '0;
        if (state_q == S_XFER)
            req_ready[grant_q] = ~pkt_tx_full;
        else if (state_q == S_DRAIN)
            req_ready[grant_q] = 1'b1;
    end

    // Next-state, arbitration, beat forwarding and counter updates.
    always_comb begin
        logic          found;
        logic [GW-1:0] win;
        int unsigned   idx;
        state_d   = state_q;
        grant_d   = grant_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        tx_val_d  = 1'b0;
        tx_sop_d  = 1'b0;
        tx_eop_d  = 1'b0;
        tx_data_d = '0;
        tx_mod_d  = '0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        found     = 1'b0;
        win       = grant_q;
        idx       = 0;
        case (state_q)
            S_IDLE: begin
                // Search starts just after the last winner so it becomes lowest priority.
                for (int unsigned i = 1; i <= NREQ; i++) begin
                    idx = (32'(grant_q) + i) % NREQ;
                    if (!found && cand[idx[GW-1:0]]) begin
                        found = 1'b1;
                        win   = idx[GW-1:0];
                    end
                end
                if (found) begin
                    grant_d = win;
                    beat_d  = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (sel_val && !pkt_tx_full) begin
                    tx_val_d  = 1'b1;
                    tx_sop_d  = (beat_q == 8'd0);
                    tx_data_d = sel_data;
                    beat_d    = beat_q + 8'd1;
                    if (beat_q != 8'd0 && sel_sop)
                        err_inc = 1'b1;
                    if (sel_eop) begin
                        tx_eop_d  = 1'b1;
                        tx_mod_d  = sel_mod;
                        frame_inc = 1'b1;
                        gap_d     = '0;
                        state_d   = S_POST;
                    end else if (beat_q == 8'(MAX_BEATS - 1)) begin
                        tx_eop_d  = 1'b1;
                        frame_inc = 1'b1;
                        err_inc   = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (sel_val && sel_eop) begin
                    gap_d   = '0;
                    state_d = S_POST;
                end
            end
            default: begin
                if (gap_q == 8'(IFG_CYCLES - 1))
                    state_d = S_IDLE;
                else
                    gap_d = gap_q + 8'd1;
            end
        endcase
        frame_d = (frame_inc && frame_q != '1) ? frame_q + 32'd1 : frame_q;
        err_d   = (err_inc && err_q != '1) ? err_q + 16'd1 : err_q;
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q   <= S_IDLE;
            grant_q   <= GW'(NUM_REQ - 1);
            beat_q    <= '0;
            gap_q     <= '0;
            tx_val_q  <= 1'b0;
            tx_sop_q  <= 1'b0;
            tx_eop_q  <= 1'b0;
            tx_data_q <= '0;
            tx_mod_q  <= '0;
            frame_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
            gap_q     <= gap_d;
            tx_val_q  <= tx_val_d;
            tx_sop_q  <= tx_sop_d;
            tx_eop_q  <= tx_eop_d;
            tx_data_q <= tx_data_d;
            tx_mod_q  <= tx_mod_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
        end
    end

    assign pkt_tx_val  = tx_val_q;
    assign pkt_tx_sop  = tx_sop_q;
    assign pkt_tx_eop  = tx_eop_q;
    assign pkt_tx_data = tx_data_q;
    assign pkt_tx_mod  = tx_mod_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_cnt   = frame_q;
    assign err_cnt     = err_q;

endmodule
